// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, sequencer states and slice width shared by alu_nibble_sequencer
package alu_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_SLTFIX = 2'd2,
    SEQ_DONE   = 2'd3
  } seq_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu4bit.sv
// rtl/alu4bit.sv - ALU4Bit: 4-bit AND/OR/ADD/LESS slice with b-invert, carry chain and signed set
module ALU4Bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_op,
  input  logic       i_cin,
  input  logic       i_less,
  output logic [3:0] o_result,
  output logic       o_cout,
  output logic       o_overflow,
  output logic       o_set
);

  logic [3:0] w_b;
  logic [4:0] w_sum;
  logic       w_c3;

  assign w_b   = i_op[2] ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {4'b0000, i_cin};
  assign w_c3  = i_a[3] ^ w_b[3] ^ w_sum[3];

  assign o_cout     = w_sum[4];
  assign o_overflow = w_c3 ^ w_sum[4];
  // set is overflow-corrected so SLT is a true signed compare
  assign o_set      = w_sum[3] ^ o_overflow;

  always_comb begin
    o_result = 4'b0000;
    case (i_op[1:0])
      2'b00:   o_result = i_a & w_b;
      2'b01:   o_result = i_a | w_b;
      2'b10:   o_result = w_sum[3:0];
      default: o_result = {3'b000, i_less};
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - runs W-bit ALU ops through one ALU4Bit slice, one nibble per clock
// Optional macro ALU_SEQ_ILLEGAL_OP_EN adds out_illegal and short-circuits unlisted op codes.
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic [2:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_result,
  output logic                      out_cout,
  output logic                      out_overflow,
  output logic                      out_zero,
  output logic                      busy
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  ,
  output logic                      out_illegal
`endif
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE   = SEQ_IDLE;
  localparam logic [1:0] S_RUN    = SEQ_RUN;
  localparam logic [1:0] S_SLTFIX = SEQ_SLTFIX;
  localparam logic [1:0] S_DONE   = SEQ_DONE;

  logic [1:0]    r_state;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_op;
  logic          r_carry;
  logic          r_set;
  logic          r_cout_last;
  logic [W-1:0]  r_res;
  logic [W-1:0]  r_out_result;
  logic          r_out_cout;
  logic          r_out_ovf;
  logic          r_out_zero;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic          r_out_illegal;
`endif

  logic [KW-1:0] w_idx;
  logic [KW+1:0] w_base;
  logic          w_last;
  logic          w_cin;
  logic          w_less;
  logic [3:0]    w_sres;
  logic          w_cout;
  logic          w_ovf;
  logic          w_set;
  logic [W-1:0]  w_res_next;
  logic          w_addsub;

  // SLTFIX revisits nibble 0 regardless of where the index ended up
  assign w_idx    = (r_state == S_SLTFIX) ? '0 : r_k;
  assign w_base   = {w_idx, 2'b00};
  assign w_last   = (r_k == KW'(NIBBLES - 1));
  assign w_cin    = (r_state == S_SLTFIX) ? 1'b1 : ((r_k == '0) ? r_op[2] : r_carry);
  assign w_less   = (r_state == S_SLTFIX) & r_set;
  assign w_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);

  ALU4Bit u_slice (
    .i_a        (r_a[w_base +: NIBBLE_W]),
    .i_b        (r_b[w_base +: NIBBLE_W]),
    .i_op       (r_op),
    .i_cin      (w_cin),
    .i_less     (w_less),
    .o_result   (w_sres),
    .o_cout     (w_cout),
    .o_overflow (w_ovf),
    .o_set      (w_set)
  );

  always_comb begin
    w_res_next = r_res;
    if (r_state == S_RUN || r_state == S_SLTFIX) begin
      w_res_next[w_base +: NIBBLE_W] = w_sres;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_op          <= '0;
      r_carry       <= 1'b0;
      r_set         <= 1'b0;
      r_cout_last   <= 1'b0;
      r_res         <= '0;
      r_out_result  <= '0;
      r_out_cout    <= 1'b0;
      r_out_ovf     <= 1'b0;
      r_out_zero    <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      r_out_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= in_op;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
            if (!is_legal_op(in_op)) begin
              r_state       <= S_DONE;
              r_out_result  <= '0;
              r_out_cout    <= 1'b0;
              r_out_ovf     <= 1'b0;
              r_out_zero    <= 1'b1;
              r_out_illegal <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
`else
            r_state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_k     <= r_k + 1'b1;
          if (w_last) begin
            r_set       <= w_set;
            r_cout_last <= w_cout;
            if (r_op == OP_SLT) begin
              r_state <= S_SLTFIX;
            end else begin
              r_state       <= S_DONE;
              r_out_result  <= w_res_next;
              r_out_cout    <= w_cout;
              r_out_ovf     <= w_ovf & w_addsub;
              r_out_zero    <= (w_res_next == '0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
              r_out_illegal <= 1'b0;
`endif
            end
          end
        end
        S_SLTFIX: begin
          r_res         <= w_res_next;
          r_state       <= S_DONE;
          r_out_result  <= w_res_next;
          r_out_cout    <= r_cout_last;
          r_out_ovf     <= 1'b0;
          r_out_zero    <= (w_res_next == '0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
          r_out_illegal <= 1'b0;
`endif
        end
        default: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign out_result   = r_out_result;
  assign out_cout     = r_out_cout;
  assign out_overflow = r_out_ovf;
  assign out_zero     = r_out_zero;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  assign out_illegal  = r_out_illegal & out_valid;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - self-checking bench for alu_nibble_sequencer (16-bit, default build)
module tb_alu_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_cout;
  logic        out_overflow;
  logic        out_zero;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .busy         (busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Whole-word reference: W-bit arithmetic with signed compare, no nibble detail
  task automatic ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic cout, output logic ovf);
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, (op[2] ? ~b : b)} + {16'd0, op[2]};
    cout = full[16];
    ovf  = 1'b0;
    res  = 16'h0;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        res = full[15:0];
        ovf = (a[15] == b[15]) && (res[15] != a[15]);
      end
      3'b110: begin
        res = full[15:0];
        ovf = (a[15] != b[15]) && (res[15] != a[15]);
      end
      3'b111: res = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
      default: res = 16'h0;
    endcase
  endtask

  // Issues one request; returns cycles from accept edge to out_valid, leaves DUT in DONE
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output bit ok);
    int guard;
    ok = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_op = 3'($urandom);
    lat = 0;
    while (!ok && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) ok = 1'b1;
    end
    if (!ok) check("timeout_out_valid", 32'(ok), 32'd1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bit ok;
    logic [15:0] e_res;
    logic e_cout, e_ovf;
    logic [15:0] held;

    vecs[0] = '{3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 4};
    vecs[1] = '{3'b110, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 4};
    vecs[2] = '{3'b111, 16'hFFFE, 16'h0003, 16'h0001, 1'b1, 1'b0, 1'b0, 5};
    vecs[3] = '{3'b111, 16'h0003, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 5};
    vecs[4] = '{3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b0, 1'b0, 4};
    vecs[5] = '{3'b001, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b1, 1'b0, 1'b0, 4};
    vecs[6] = '{3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 4};
    vecs[7] = '{3'b110, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4};

    #3;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(out_result), 32'd0);
    check("reset_zero", 32'(out_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].res));
        check($sformatf("vec%0d_cout", i), 32'(out_cout), 32'(vecs[i].cout));
        check($sformatf("vec%0d_ovf", i), 32'(out_overflow), 32'(vecs[i].ovf));
        check($sformatf("vec%0d_zero", i), 32'(out_zero), 32'(vecs[i].zero));
        check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        check($sformatf("vec%0d_in_ready_done", i), 32'(in_ready), 32'd0);
      end
      release_result();
      check($sformatf("vec%0d_release", i), {30'd0, out_valid, in_ready}, 32'd1);
      check($sformatf("vec%0d_retain", i), 32'(out_result), 32'(vecs[i].res));
    end

    // Backpressure: DONE held for three cycles
    issue(3'b010, 16'h1111, 16'h2222, lat, ok);
    held = 16'h3333;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_result", c), 32'(out_result), 32'(held));
    end
    release_result();

    // Reset in RUN at k = 2, then a clean request
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 16'h0F0F;
    in_b = 16'h0101;
    in_op = 3'b010;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(out_result), 32'd0);
    check("midrst_flags", {29'd0, out_cout, out_overflow, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b110, 16'h0005, 16'h0007, lat, ok);
    if (ok) begin
      check("postrst_result", 32'(out_result), 32'h0000FFFE);
      check("postrst_latency", 32'(lat), 32'd4);
    end
    release_result();

    // Randomized against the reference model; unlisted ops need only complete
    for (int r = 0; r < 40; r++) begin
      logic [2:0] op;
      logic [15:0] a, b;
      int pick;
      pick = int'($urandom_range(0, 6));
      case (pick)
        0: op = 3'b000;
        1: op = 3'b001;
        2: op = 3'b010;
        3: op = 3'b110;
        4: op = 3'b111;
        default: op = (pick == 5) ? 3'b011 : 3'b101;
      endcase
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      issue(op, a, b, lat, ok);
      if (ok) begin
        if (op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111}) begin
          ref_model(op, a, b, e_res, e_cout, e_ovf);
          check($sformatf("rnd%0d_result", r), 32'(out_result), 32'(e_res));
          check($sformatf("rnd%0d_cout", r), 32'(out_cout), 32'(e_cout));
          check($sformatf("rnd%0d_ovf", r), 32'(out_overflow), 32'(e_ovf));
          check($sformatf("rnd%0d_zero", r), 32'(out_zero), 32'(e_res == 16'h0));
          check($sformatf("rnd%0d_latency", r), 32'(lat), (op == 3'b111) ? 32'd5 : 32'd4);
        end else begin
          check($sformatf("rnd%0d_unlisted_latency", r), 32'(lat), 32'd4);
        end
      end
      release_result();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
